// File: rtl/oka_pkg.sv
// Shared types and helpers for the sequenced OKA multipliers.
// Even/odd splitting and small carry-less products over GF(2).
package oka_pkg;

    localparam int OKA15_N    = 15;
    localparam int OKA15_HALF = 8;

    typedef enum logic [2:0] {
        IDLE,
        MUL_E,
        MUL_O,
        MUL_M,
        DONE
    } oka_state_e;

    // Coefficients of x^0, x^2, ... packed into consecutive bits.
    function automatic logic [OKA15_HALF-1:0] even_bits(
        input logic [OKA15_N-1:0] v
    );
        logic [OKA15_HALF-1:0] r;
        r = '0;
        for (int i = 0; i < OKA15_HALF; i++) begin
            r[i] = v[2*i];
        end
        return r;
    endfunction

    function automatic logic [OKA15_HALF-1:0] odd_bits(
        input logic [OKA15_N-1:0] v
    );
        logic [OKA15_HALF-1:0] r;
        r = '0;
        for (int i = 0; i < OKA15_HALF - 1; i++) begin
            r[i] = v[2*i+1];
        end
        return r;
    endfunction

    function automatic logic [6:0] clmul4(
        input logic [3:0] x,
        input logic [3:0] y
    );
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (x[i]) begin
                r = r ^ (7'(y) << i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/oka_8bit.sv
// 8x8 carry-less multiplier, one Karatsuba level over 4-bit halves.
// Purely combinational; 15-bit product.
module oka_8bit
    import oka_pkg::*;
(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [14:0] p
);

    logic [6:0] pl;
    logic [6:0] ph;
    logic [6:0] pm;
    logic [6:0] mid;

    always_comb begin
        pl  = clmul4(a[3:0], b[3:0]);
        ph  = clmul4(a[7:4], b[7:4]);
        pm  = clmul4(a[3:0] ^ a[7:4], b[3:0] ^ b[7:4]);
        mid = pm ^ pl ^ ph;
        p   = {ph, 8'h00}
            ^ {4'h0, mid, 4'h0}
            ^ {8'h00, pl};
    end

endmodule

// File: rtl/oka_15bit_seq.sv
// 15x15 carry-less multiplier sharing one 8-bit core over three cycles.
// Even/odd split: a = ae(x^2) + x*ao(x^2), same for b.
module oka_15bit_seq
    import oka_pkg::*;
#(
    parameter int N = OKA15_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] y,
    output logic           busy
);

    localparam int HALF = (N + 1) / 2;

    oka_state_e state;

    logic [N-1:0]      a_q;
    logic [N-1:0]      b_q;
    logic [2*HALF-2:0] pe_q;
    logic [2*HALF-2:0] po_q;

    logic [HALF-1:0]   core_a;
    logic [HALF-1:0]   core_b;
    logic [2*HALF-2:0] pm;
    logic [2*HALF-2:0] pmid;
    logic [2*N-2:0]    y_next;
    logic              unused_hi;

    // Core inputs follow state only; idle states feed zeros.
    always_comb begin
        core_a = '0;
        core_b = '0;
        unique case (state)
            MUL_E: begin
                core_a = even_bits(a_q);
                core_b = even_bits(b_q);
            end
            MUL_O: begin
                core_a = odd_bits(a_q);
                core_b = odd_bits(b_q);
            end
            MUL_M: begin
                core_a = even_bits(a_q) ^ odd_bits(a_q);
                core_b = even_bits(b_q) ^ odd_bits(b_q);
            end
            default: begin
                core_a = '0;
                core_b = '0;
            end
        endcase
    end

    oka_8bit u_core (
        .a (core_a),
        .b (core_b),
        .p (pm)
    );

    // Even output bits from pe/po, odd bits from the Karatsuba middle term.
    always_comb begin
        pmid      = pm ^ pe_q ^ po_q;
        y_next    = '0;
        y_next[0] = pe_q[0];
        for (int k = 1; k < HALF * 2 - 1; k++) begin
            y_next[2*k] = pe_q[k] ^ po_q[k-1];
        end
        for (int k = 0; k < HALF * 2 - 2; k++) begin
            y_next[2*k+1] = pmid[k];
        end
        unused_hi = pmid[2*HALF-2] ^ po_q[2*HALF-2];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            y         <= '0;
            a_q       <= '0;
            b_q       <= '0;
            pe_q      <= '0;
            po_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL_E;
                    end
                end
                MUL_E: begin
                    pe_q  <= pm;
                    state <= MUL_O;
                end
                MUL_O: begin
                    po_q  <= pm;
                    state <= MUL_M;
                end
                MUL_M: begin
                    y         <= y_next;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oka_15bit_seq.sv
// Bench for oka_15bit_seq: directed cases, back-pressure, reset, soak.
// Reference is a plain shift-and-xor carry-less multiply.
module tb_oka_15bit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] a;
    logic [14:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [28:0] y;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int n_out  = 0;
    int n_abort = 0;

    always #5 clk = ~clk;

    oka_15bit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) n_acc <= n_acc + 1;
        if (rst_n && out_valid && out_ready) n_out <= n_out + 1;
    end

    function automatic logic [28:0] clmul(input logic [14:0] x,
                                          input logic [14:0] z);
        logic [28:0] r;
        r = '0;
        for (int i = 0; i < 15; i++) begin
            if (x[i]) r = r ^ (29'(z) << i);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Accept one pair, check latency and y, stall, then hand off.
    task automatic txn(input logic [14:0] ta, input logic [14:0] tb_v,
                       input int stall, input string tag);
        logic [28:0] exp;
        int n;
        exp = clmul(ta, tb_v);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        tick();
        in_valid = 1'b0;
        a = 15'($urandom);
        b = 15'($urandom);
        chk({tag, "_busy"}, 32'({in_ready, busy}), 32'b01);
        tick();
        tick();
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        chk({tag, "_y"}, 32'(y), 32'(exp));
        for (int s = 0; s < stall; s++) begin
            tick();
            chk({tag, "_hold"}, 32'({out_valid, y}), 32'({1'b1, exp}));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, 32'({out_valid, in_ready, busy}), 32'b010);
        chk({tag, "_ykeep"}, 32'(y), 32'(exp));
    endtask

    initial begin
        logic [28:0] exp;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        rst_n = 1'b1;
        tick();

        txn(15'h0001, 15'h0001, 0, "one");
        chk("one_const", 32'(y), 32'h0000001);
        txn(15'h0003, 15'h0003, 1, "three");
        chk("three_const", 32'(y), 32'h0000005);
        txn(15'h7FFF, 15'h0001, 0, "ones");
        chk("ones_const", 32'(y), 32'h0007FFF);
        txn(15'h4000, 15'h4000, 2, "top");
        chk("top_const", 32'(y), 32'h10000000);
        txn(15'h0002, 15'h0002, 0, "odd");
        chk("odd_const", 32'(y), 32'h0000004);
        txn(15'h7FFF, 15'h7FFF, 0, "full");

        // Back-pressure with an ignored in_valid pulse.
        exp = clmul(15'h0ABC, 15'h5321);
        in_valid = 1'b1;
        a = 15'h0ABC;
        b = 15'h5321;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("bp_ovalid", 32'(out_valid), 32'd1);
        for (int s = 0; s < 6; s++) begin
            if (s == 2) begin
                in_valid = 1'b1;
                a = 15'h1234;
                b = 15'h1234;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("bp_state", 32'({out_valid, in_ready, busy}), 32'b101);
            chk("bp_y", 32'(y), 32'(exp));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drop", 32'({out_valid, in_ready}), 32'b01);

        // Reset while the core is on the odd product.
        in_valid = 1'b1;
        a = 15'h7777;
        b = 15'h2AAA;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        n_abort++;
        tick();
        chk("mr_state", 32'({out_valid, in_ready, busy}), 32'b010);
        chk("mr_y", 32'(y), 32'd0);
        rst_n = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("mr_quiet", 32'(out_valid), 32'd0);
        end
        txn(15'h0003, 15'h0003, 0, "after_rst");
        chk("after_rst_const", 32'(y), 32'h0000005);

        for (int i = 0; i < 10000; i++) begin
            int st;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            txn(15'($urandom), 15'($urandom), st, "soak");
        end

        tick();
        chk("handshakes", 32'(n_out), 32'(n_acc - n_abort));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
